uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Sequencing and buffering controller for the UART receiver. It holds the receiver's run-time configuration (prescale, parity enable, parity type) and applies host updates only after the serial line has been idle for a full maximum-length frame, so a change never lands mid-frame. It also captures every byte the receiver flags as valid into a first-word-fall-through FIFO, which a downstream consumer drains with a valid/ready handshake. It sits between the host/register side and `UART_RX_TOP`.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2.
- `AW`, `$clog2(DEPTH)`, derived pointer width; not overridden.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `cfg_wr`  in  1  one-cycle configuration update request.
- `cfg_prescale`  in  5  requested oversampling factor.
- `cfg_par_en`  in  1  requested parity enable.
- `cfg_par_typ`  in  1  requested parity type (0 even, 1 odd).
- `cfg_busy`  out  1  an accepted update is not yet applied.
- `cfg_err`  out  1  one-cycle pulse: the update request was rejected.
- `rx_in`  in  1  serial line, monitored for idle.
- `prescale`  out  5  to receiver.
- `par_en`  out  1  to receiver.
- `par_typ`  out  1  to receiver.
- `rx_data_valid`  in  1  receiver byte strobe, one cycle per frame.
- `rx_p_data`  in  8  receiver parallel byte.
- `m_valid`  out  1  FIFO not empty.
- `m_data`  out  8  FIFO head byte.
- `m_ready`  in  1  consumer accepts the head byte.
- `fifo_count`  out  AW+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a byte was dropped.
- `ovf_clr`  in  1  clears `overflow` and `ovf_count`.
- `ovf_count`  out  8  dropped-byte count; present only with the macro.

## Operation
- Reset values:
  - Configuration outputs: `prescale`=8, `par_en`=1, `par_typ`=0.
  - Handshake and status outputs: `cfg_busy`=0, `cfg_err`=0, `m_valid`=0, `fifo_count`=0, `overflow`=0, `ovf_count`=0.
  - FSM state: RUN.
  - Shadow registers, idle counter and FIFO pointers are cleared.
- Legal `cfg_prescale` values are 8 and 16. Any other value is rejected: `cfg_err` pulses for one cycle and all state is unchanged.
- FSM states are RUN, PEND and APPLY.
  - RUN: a legal `cfg_wr` loads the shadow registers, clears `idle_cnt` and moves to PEND.
  - PEND:
    - `rx_in`=0 clears `idle_cnt`; `rx_in`=1 increments it.
    - The terminal value is `11*prescale-1`, computed from the current, not the shadow, prescale. `idle_cnt` is 9 bits wide.
    - A legal `cfg_wr` in PEND overwrites the shadow registers and does not restart `idle_cnt`.
  - PEND→APPLY: on the edge where `idle_cnt`=terminal and `rx_in`=1, the FSM enters APPLY and `prescale`/`par_en`/`par_typ` load the shadow values on that same edge.
  - APPLY: lasts exactly one cycle, then RUN. Any `cfg_wr` in APPLY is rejected with `cfg_err`.
- `cfg_busy` = (state ≠ RUN).
- FIFO push and pop:
  - Push occurs in every cycle where `rx_data_valid`=1.
  - Pop occurs when `m_valid`&&`m_ready`.
  - `m_data` is `mem[rd_ptr]`, combinational (first-word fall-through). When empty, `m_data` is don't-care.
  - Pointers are AW bits and wrap modulo DEPTH. Full/empty are derived from `fifo_count`.
- FIFO boundary cases:
  - Push while full with no pop: the byte is dropped and `overflow` is set.
  - Push and pop in the same cycle while full: both happen, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: only the push happens, because `m_valid`=0.
  - `ovf_clr` together with a new drop: set wins, `overflow` stays 1.
- Reset asserted mid-frame or in PEND returns everything to the reset values. Any pending update is lost.

## Timing
- Push at edge N: `m_valid`=1 and `fifo_count` incremented in cycle N+1.
- Pop at edge N: the next entry appears on `m_data` in cycle N+1.
- `cfg_err` is registered; it is high in the cycle after the rejected `cfg_wr`.
- Minimum apply latency from `cfg_wr` with the line held idle:
  - `cfg_wr` at edge 0 enters PEND.
  - Configuration outputs change at edge `11*prescale`.
  - `cfg_busy` falls one edge later.

## Configuration
- `UART_RX_CTRL_OVF_CNT_EN` defined:
  - `ovf_count` port exists and counts dropped bytes.
  - It saturates at 255.
  - It is cleared by `ovf_clr`; an increment in the same cycle wins, giving a result of 1.
- Undefined: `ovf_count` port and its logic are absent. `overflow` behaves identically in both builds.

## Structure
- Shared package `uart_rx_pkg`:
  - Reset configuration constants: `PRESCALE_RST`=8, `PAR_EN_RST`=1, `PAR_TYP_RST`=0.
  - `FRAME_BITS_MAX`=11.
  - Legal prescale constants.
  - FSM state enum.
- One sub-module, `uart_rx_fifo` (parameterised by DEPTH; push/pop/full/empty/count, FWFT). The FSM and config shadow registers stay in the top level.

## Test plan
- After reset: `prescale`=8, `par_en`=1, `par_typ`=0, `m_valid`=0, `fifo_count`=0.
- `cfg_wr` with prescale=16, line idle → `cfg_busy`=1. Outputs change exactly 88 cycles after the request edge. `cfg_busy`=0 one cycle later.
- `cfg_wr` in PEND; `rx_in` pulled low at idle_cnt=50 for 3 cycles → counter restarts. Apply happens 88 cycles after `rx_in` returns high.
- `cfg_prescale`=12 → `cfg_err` pulse, no state change. `cfg_wr` during APPLY → `cfg_err`.
- Push 0x11..0x19 with DEPTH=8 and `m_ready`=0 → `fifo_count`=8, `overflow`=1, `ovf_count`=1. Drain order is 0x11..0x18.
- With the FIFO full, push 0xAA and pop in the same cycle → count stays 8, no new overflow, 0xAA is the last entry. `ovf_clr` together with a drop → `overflow` stays 1.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared constants, FSM state enum and configuration payload for the UART receiver control slice.
package uart_rx_pkg;

  localparam int unsigned PS_W           = 5;
  localparam int unsigned IDLE_W         = 9;
  localparam int unsigned FRAME_BITS_MAX = 11;

  localparam logic [PS_W-1:0] PRESCALE_RST = 5'd8;
  localparam logic            PAR_EN_RST   = 1'b1;
  localparam logic            PAR_TYP_RST  = 1'b0;

  localparam logic [PS_W-1:0] PRESCALE_8  = 5'd8;
  localparam logic [PS_W-1:0] PRESCALE_16 = 5'd16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_APPLY = 2'd2
  } ctrl_state_e;

  // Receiver run-time configuration payload.
  typedef struct packed {
    logic [PS_W-1:0] prescale;
    logic            par_en;
    logic            par_typ;
  } rx_cfg_t;

  localparam rx_cfg_t CFG_RST = '{prescale: PRESCALE_RST, par_en: PAR_EN_RST, par_typ: PAR_TYP_RST};

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO.
// Ports: clk, rst (async active-low); push/push_data write side;
// pop_ready consumer handshake; m_valid/m_data head of queue (m_data is
// combinational from storage); count occupancy; drop_c flags a push lost
// because the FIFO was full and nothing was popped.
module uart_rx_fifo #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop_ready,
  output logic          m_valid,
  output logic [7:0]    m_data,
  output logic [AW:0]   count,
  output logic          drop_c
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full_c;
  logic          pop_c;
  logic          push_ok_c;
  logic [AW:0]   count_nxt_c;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign full_c    = (count == FULL_CNT);
  assign pop_c     = m_valid & pop_ready;
  assign push_ok_c = push & (~full_c | pop_c);
  assign drop_c    = push & full_c & ~pop_c;
  assign m_data    = mem[rd_ptr];

  always_comb begin
    count_nxt_c = count;
    case ({push_ok_c, pop_c})
      2'b10:   count_nxt_c = count + (AW+1)'(1);
      2'b01:   count_nxt_c = count - (AW+1)'(1);
      default: count_nxt_c = count;
    endcase
  end

  // Pointers, occupancy and registered not-empty flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      m_valid <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)     rd_ptr <= rd_ptr + AW'(1);
      count   <= count_nxt_c;
      m_valid <= (count_nxt_c != '0);
    end
  end

  // Storage needs no reset; contents are only visible while m_valid is high.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver sequencing/buffering controller.
// Holds the receiver configuration and applies host updates only after the
// line has been idle for a full maximum-length frame; buffers received bytes
// in a FWFT FIFO drained with m_valid/m_ready.
// Ports: clk, rst (async active-low); cfg_wr/cfg_prescale/cfg_par_en/
// cfg_par_typ host update, cfg_busy/cfg_err status; rx_in line monitor;
// prescale/par_en/par_typ to the receiver; rx_data_valid/rx_p_data byte
// input; m_valid/m_data/m_ready consumer side; fifo_count, overflow,
// ovf_clr; ovf_count only when UART_RX_CTRL_OVF_CNT_EN is defined.
module uart_rx_ctrl #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_wr,
  input  logic [4:0]    cfg_prescale,
  input  logic          cfg_par_en,
  input  logic          cfg_par_typ,
  output logic          cfg_busy,
  output logic          cfg_err,
  input  logic          rx_in,
  output logic [4:0]    prescale,
  output logic          par_en,
  output logic          par_typ,
  input  logic          rx_data_valid,
  input  logic [7:0]    rx_p_data,
  output logic          m_valid,
  output logic [7:0]    m_data,
  input  logic          m_ready,
  output logic [AW:0]   fifo_count,
  output logic          overflow,
  input  logic          ovf_clr
`ifdef UART_RX_CTRL_OVF_CNT_EN
  ,
  output logic [7:0]    ovf_count
`endif
);

  import uart_rx_pkg::*;

  ctrl_state_e         state, state_nxt;
  rx_cfg_t             cfg_q, shadow_q, req_c;
  logic [IDLE_W-1:0]   idle_cnt, idle_nxt;
  logic [IDLE_W-1:0]   idle_term_c;
  logic                cfg_legal_c;
  logic                shadow_ld;
  logic                apply;
  logic                err_nxt;
  logic                drop_c;

  assign req_c       = '{prescale: cfg_prescale, par_en: cfg_par_en, par_typ: cfg_par_typ};
  assign cfg_legal_c = (cfg_prescale == PRESCALE_8) || (cfg_prescale == PRESCALE_16);
  // Idle threshold follows the prescale currently in use, not the pending one.
  assign idle_term_c = IDLE_W'(FRAME_BITS_MAX) * IDLE_W'(cfg_q.prescale) - IDLE_W'(1);

  assign prescale = cfg_q.prescale;
  assign par_en   = cfg_q.par_en;
  assign par_typ  = cfg_q.par_typ;

  // Next-state, shadow load, apply and reject decisions.
  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    shadow_ld = 1'b0;
    apply     = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_RUN: begin
        if (cfg_wr) begin
          if (cfg_legal_c) begin
            shadow_ld = 1'b1;
            idle_nxt  = '0;
            state_nxt = ST_PEND;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_PEND: begin
        if (cfg_wr) begin
          if (cfg_legal_c) shadow_ld = 1'b1;
          else             err_nxt   = 1'b1;
        end
        if (!rx_in) begin
          idle_nxt = '0;
        end else if (idle_cnt == idle_term_c) begin
          apply     = 1'b1;
          state_nxt = ST_APPLY;
        end else begin
          idle_nxt = idle_cnt + IDLE_W'(1);
        end
      end
      ST_APPLY: begin
        state_nxt = ST_RUN;
        if (cfg_wr) err_nxt = 1'b1;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // FSM state, shadow/applied configuration and status flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      idle_cnt <= '0;
      shadow_q <= '0;
      cfg_q    <= CFG_RST;
      cfg_busy <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_nxt;
      cfg_busy <= (state_nxt != ST_RUN);
      cfg_err  <= err_nxt;
      if (shadow_ld) shadow_q <= req_c;
      // A legal write landing on the apply edge is the newest request, so forward it.
      if (apply)     cfg_q    <= shadow_ld ? req_c : shadow_q;
    end
  end

  uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_data_valid),
    .push_data (rx_p_data),
    .pop_ready (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .count     (fifo_count),
    .drop_c    (drop_c)
  );

  // Sticky overflow; a new drop wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         overflow <= 1'b0;
    else if (drop_c)  overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

`ifdef UART_RX_CTRL_OVF_CNT_EN
  // Saturating drop counter; a drop coinciding with a clear restarts at 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_count <= '0;
    end else if (drop_c) begin
      if (ovf_clr)                 ovf_count <= 8'd1;
      else if (ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
    end else if (ovf_clr) begin
      ovf_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed configuration sequencing checks plus a
// queue-based scoreboard for the FIFO consumer side.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_wr;
  logic [4:0]    cfg_prescale;
  logic          cfg_par_en;
  logic          cfg_par_typ;
  logic          cfg_busy;
  logic          cfg_err;
  logic          rx_in;
  logic [4:0]    prescale;
  logic          par_en;
  logic          par_typ;
  logic          rx_data_valid;
  logic [7:0]    rx_p_data;
  logic          m_valid;
  logic [7:0]    m_data;
  logic          m_ready;
  logic [AW:0]   fifo_count;
  logic          overflow;
  logic          ovf_clr;
`ifdef UART_RX_CTRL_OVF_CNT_EN
  logic [7:0]    ovf_count;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_wr        (cfg_wr),
    .cfg_prescale  (cfg_prescale),
    .cfg_par_en    (cfg_par_en),
    .cfg_par_typ   (cfg_par_typ),
    .cfg_busy      (cfg_busy),
    .cfg_err       (cfg_err),
    .rx_in         (rx_in),
    .prescale      (prescale),
    .par_en        (par_en),
    .par_typ       (par_typ),
    .rx_data_valid (rx_data_valid),
    .rx_p_data     (rx_p_data),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .ovf_clr       (ovf_clr)
`ifdef UART_RX_CTRL_OVF_CNT_EN
    ,
    .ovf_count     (ovf_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle configuration request; returns just after the capturing edge.
  task automatic cfg_req(input logic [4:0] ps, input logic pe, input logic pt);
    cfg_wr = 1'b1; cfg_prescale = ps; cfg_par_en = pe; cfg_par_typ = pt;
    tick(1);
    cfg_wr = 1'b0;
  endtask

  // Scoreboard monitor: every accepted head byte must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("m_data_unexpected", 32'(m_data), 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("m_data", 32'(m_data), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cfg_wr = 1'b0; cfg_prescale = 5'd8; cfg_par_en = 1'b1; cfg_par_typ = 1'b0;
    rx_in = 1'b1; rx_data_valid = 1'b0; rx_p_data = 8'h00; m_ready = 1'b0; ovf_clr = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);

    // Reset state
    check("rst_prescale", 32'(prescale), 32'd8);
    check("rst_par_en", 32'(par_en), 32'd1);
    check("rst_par_typ", 32'(par_typ), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_cfg_busy", 32'(cfg_busy), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
`ifdef UART_RX_CTRL_OVF_CNT_EN
    check("rst_ovf_count", 32'(ovf_count), 32'd0);
`endif

    // Illegal prescale in RUN is rejected
    cfg_req(5'd12, 1'b0, 1'b1);
    check("illegal_err", 32'(cfg_err), 32'd1);
    check("illegal_busy", 32'(cfg_busy), 32'd0);
    check("illegal_prescale", 32'(prescale), 32'd8);
    tick(1);
    check("illegal_err_pulse", 32'(cfg_err), 32'd0);

    // Idle counter restart, PEND overwrite without restart, illegal write in PEND
    cfg_req(5'd16, 1'b0, 1'b1);
    check("restart_busy0", 32'(cfg_busy), 32'd1);
    tick(50);
    rx_in = 1'b0;
    tick(3);
    rx_in = 1'b1;
    for (int i = 1; i <= 88; i++) begin
      cfg_wr       = (i == 40) || (i == 60);
      cfg_prescale = (i == 60) ? 5'd12 : 5'd16;
      cfg_par_en   = 1'b1;
      cfg_par_typ  = 1'b1;
      tick(1);
      cfg_wr = 1'b0;
      if (i == 60) check("pend_illegal_err", 32'(cfg_err), 32'd1);
      if (i == 87) begin
        check("restart_hold_prescale", 32'(prescale), 32'd8);
        check("restart_hold_busy", 32'(cfg_busy), 32'd1);
      end
    end
    check("restart_apply_prescale", 32'(prescale), 32'd16);
    check("restart_apply_par_en", 32'(par_en), 32'd1);
    check("restart_apply_par_typ", 32'(par_typ), 32'd1);
    check("restart_apply_busy", 32'(cfg_busy), 32'd1);

    // Write during APPLY is rejected
    cfg_req(5'd8, 1'b0, 1'b0);
    check("apply_err", 32'(cfg_err), 32'd1);
    check("apply_busy_fall", 32'(cfg_busy), 32'd0);
    check("apply_keep_prescale", 32'(prescale), 32'd16);
    tick(1);

    // Reset while PEND drops the pending update
    cfg_req(5'd8, 1'b0, 1'b0);
    tick(30);
    check("pend_busy", 32'(cfg_busy), 32'd1);
    rst = 1'b0;
    #2;
    check("midrst_prescale", 32'(prescale), 32'd8);
    check("midrst_par_typ", 32'(par_typ), 32'd0);
    check("midrst_busy", 32'(cfg_busy), 32'd0);
    tick(2);
    rst = 1'b1;
    tick(100);
    check("midrst_lost_par_en", 32'(par_en), 32'd1);
    check("midrst_lost_busy", 32'(cfg_busy), 32'd0);

    // Minimum apply latency from prescale 8
    cfg_req(5'd16, 1'b0, 1'b1);
    check("lat_busy", 32'(cfg_busy), 32'd1);
    tick(87);
    check("lat_hold_prescale", 32'(prescale), 32'd8);
    tick(1);
    check("lat_prescale", 32'(prescale), 32'd16);
    check("lat_par_en", 32'(par_en), 32'd0);
    check("lat_par_typ", 32'(par_typ), 32'd1);
    check("lat_busy_apply", 32'(cfg_busy), 32'd1);
    tick(1);
    check("lat_busy_fall", 32'(cfg_busy), 32'd0);

    // Fill past full with no consumer
    m_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rx_data_valid = 1'b1;
      rx_p_data     = 8'(8'h11 + i);
      if (i < 8) exp_q.push_back(8'(8'h11 + i));
      tick(1);
      if (i == 0) begin
        check("push1_m_valid", 32'(m_valid), 32'd1);
        check("push1_count", 32'(fifo_count), 32'd1);
      end
      if (i == 7) check("full_no_ovf", 32'(overflow), 32'd0);
    end
    rx_data_valid = 1'b0;
    check("full_count", 32'(fifo_count), 32'd8);
    check("full_overflow", 32'(overflow), 32'd1);
    check("full_m_valid", 32'(m_valid), 32'd1);
`ifdef UART_RX_CTRL_OVF_CNT_EN
    check("full_ovf_count", 32'(ovf_count), 32'd1);
`endif
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("clr_overflow", 32'(overflow), 32'd0);
`ifdef UART_RX_CTRL_OVF_CNT_EN
    check("clr_ovf_count", 32'(ovf_count), 32'd0);
`endif

    // Push and pop together while full
    rx_data_valid = 1'b1; rx_p_data = 8'hAA; m_ready = 1'b1;
    exp_q.push_back(8'hAA);
    tick(1);
    rx_data_valid = 1'b0; m_ready = 1'b0;
    check("pushpop_full_count", 32'(fifo_count), 32'd8);
    check("pushpop_full_ovf", 32'(overflow), 32'd0);

    // Clear coinciding with a drop: set wins
    rx_data_valid = 1'b1; rx_p_data = 8'hBB; ovf_clr = 1'b1;
    tick(1);
    rx_data_valid = 1'b0; ovf_clr = 1'b0;
    check("clr_drop_overflow", 32'(overflow), 32'd1);
    check("clr_drop_count", 32'(fifo_count), 32'd8);
`ifdef UART_RX_CTRL_OVF_CNT_EN
    check("clr_drop_ovf_count", 32'(ovf_count), 32'd1);
`endif

    // Drain
    m_ready = 1'b1;
    tick(8);
    m_ready = 1'b0;
    check("drain_count", 32'(fifo_count), 32'd0);
    check("drain_m_valid", 32'(m_valid), 32'd0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);

    // Push and pop together while empty: only the push lands
    m_ready = 1'b1; rx_data_valid = 1'b1; rx_p_data = 8'h55;
    exp_q.push_back(8'h55);
    tick(1);
    rx_data_valid = 1'b0;
    check("empty_pushpop_count", 32'(fifo_count), 32'd1);
    check("empty_pushpop_valid", 32'(m_valid), 32'd1);
    tick(1);
    m_ready = 1'b0;
    check("empty_pushpop_after", 32'(fifo_count), 32'd0);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
